// File: rtl/mem_align_pkg.sv
// mem_align_pkg: funct3 codes, FSM states, access size, legality, lane count
package mem_align_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LD0, S_LD1, S_LDC, S_ST0, S_ST1, S_RSP} state_e;
  localparam logic [2:0] F3_B = 3'd0, F3_H = 3'd1, F3_W = 3'd2, F3_D = 3'd3,
                         F3_BU = 3'd4, F3_HU = 3'd5, F3_WU = 3'd6;
  function automatic int lanes_of(input int xlen);
    return xlen / 8;
  endfunction
  function automatic logic [3:0] f3_size(input logic [2:0] f3);
    return 4'd1 << f3[1:0];
  endfunction
  function automatic logic f3_legal(input logic [2:0] f3, input logic store, input int xlen);
    return store ? (f3 == F3_B || f3 == F3_H || f3 == F3_W || (f3 == F3_D && xlen == 64))
                 : (f3 != 3'd7 && ((f3 != F3_D && f3 != F3_WU) || xlen == 64));
  endfunction
endpackage

// File: rtl/mem_align_unit_fmt.sv
// mem_align_fmt: load extract/extend from {hi,lo}; store lane shift and w0/w1 byte masks
//   f3_i funct3, off_i byte offset, wdata_i store data, lo_i/hi_i load words
//   ld_data_o formatted load, st_lo_*/st_hi_* store data and mask for w0/w1
module mem_align_fmt
  import mem_align_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int LANES = XLEN / 8,
  localparam int OW = $clog2(LANES)
) (
  input  logic [2:0]       f3_i,
  input  logic [OW-1:0]    off_i,
  input  logic [XLEN-1:0]  wdata_i,
  input  logic [XLEN-1:0]  lo_i,
  input  logic [XLEN-1:0]  hi_i,
  output logic [XLEN-1:0]  ld_data_o,
  output logic [XLEN-1:0]  st_lo_data_o,
  output logic [XLEN-1:0]  st_hi_data_o,
  output logic [LANES-1:0] st_lo_we_o,
  output logic [LANES-1:0] st_hi_we_o
);
  logic [6:0] pad;
  logic [XLEN-1:0] left;
  logic signed [XLEN-1:0] sx;
  logic [LANES-1:0] mb;
  always_comb begin
    pad = 7'(XLEN) - {f3_size(f3_i), 3'b000};
    // push the selected bytes to the top, then shift back down to extend
    left = XLEN'({hi_i, lo_i} >> {off_i, 3'b000}) << pad;
    sx = $signed(left) >>> pad;
    ld_data_o = f3_i[2] ? left >> pad : sx;
    mb = LANES'((9'd1 << f3_size(f3_i)) - 9'd1);
    {st_hi_we_o, st_lo_we_o} = {{LANES{1'b0}}, mb} << off_i;
    {st_hi_data_o, st_lo_data_o} = {{XLEN{1'b0}}, wdata_i} << {off_i, 3'b000};
  end
endmodule

// File: rtl/mem_align_unit.sv
// mem_align_unit: load/store aligner with split/merge of word-crossing accesses
//   req_* request handshake and fields, mem_* synchronous RAM port (1-cycle read),
//   rsp_* response handshake with formatted data and error flag.
//   MEM_ALIGN_MISALIGN_TRAP_EN: trap misaligned accesses instead of splitting.
module mem_align_unit
  import mem_align_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ADDR_W = 32,
  localparam int LANES = lanes_of(XLEN),
  localparam int OW = $clog2(LANES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LANES-1:0]  mem_we,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_data,
  output logic              rsp_err
);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q, cur_addr, w0, w1, mem_addr_q, mem_addr_d;
  logic [2:0] f3_q, cur_f3;
  logic [XLEN-1:0] wdata_q, cur_wdata, lo_q, lo_d, rsp_data_q, rsp_data_d, mem_wdata_q, mem_wdata_d;
  logic [XLEN-1:0] ld_data, st_lo_data, st_hi_data;
  logic [LANES-1:0] st_lo_we, st_hi_we, mem_we_q, mem_we_d;
  logic rsp_err_q, rsp_err_d, mem_en_q, mem_en_d, split, bad;
  // in IDLE the incoming request drives the datapath so the first beat can be registered at accept
  assign cur_addr = state_q == S_IDLE ? req_addr : addr_q;
  assign cur_f3 = state_q == S_IDLE ? req_funct3 : f3_q;
  assign cur_wdata = state_q == S_IDLE ? req_wdata : wdata_q;
  assign w0 = {cur_addr[ADDR_W-1:OW], {OW{1'b0}}};
  assign w1 = w0 + ADDR_W'(LANES);
  assign split = 5'(cur_addr[OW-1:0]) + 5'(f3_size(cur_f3)) > 5'(LANES);
`ifdef MEM_ALIGN_MISALIGN_TRAP_EN
  assign bad = !f3_legal(req_funct3, req_store, XLEN) ||
               |(4'(req_addr[OW-1:0]) & (f3_size(req_funct3) - 4'd1));
`else
  assign bad = !f3_legal(req_funct3, req_store, XLEN);
`endif
  mem_align_fmt #(.XLEN(XLEN)) u_fmt (
    .f3_i(cur_f3), .off_i(cur_addr[OW-1:0]), .wdata_i(cur_wdata),
    .lo_i(split ? lo_q : mem_rdata), .hi_i(mem_rdata), .ld_data_o(ld_data),
    .st_lo_data_o(st_lo_data), .st_hi_data_o(st_hi_data),
    .st_lo_we_o(st_lo_we), .st_hi_we_o(st_hi_we)
  );
  always_comb begin
    state_d = state_q;
    lo_d = lo_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d = rsp_err_q;
    case (state_q)
      S_IDLE: if (req_valid) begin
        state_d = bad ? S_RSP : req_store ? S_ST0 : S_LD0;
        rsp_data_d = '0;
        rsp_err_d = bad;
      end
      S_LD0: state_d = split ? S_LD1 : S_LDC;
      S_LD1: begin
        lo_d = mem_rdata;
        state_d = S_LDC;
      end
      S_LDC: begin
        rsp_data_d = ld_data;
        state_d = S_RSP;
      end
      S_ST0: state_d = split ? S_ST1 : S_RSP;
      S_ST1: state_d = S_RSP;
      default: state_d = rsp_ready ? S_IDLE : S_RSP;
    endcase
    mem_en_d = state_d inside {S_LD0, S_LD1, S_ST0, S_ST1};
    mem_addr_d = (state_d == S_LD1 || state_d == S_ST1) ? w1 : mem_en_d ? w0 : mem_addr_q;
    mem_we_d = state_d == S_ST0 ? st_lo_we : state_d == S_ST1 ? st_hi_we : '0;
    mem_wdata_d = state_d == S_ST0 ? st_lo_data : state_d == S_ST1 ? st_hi_data : mem_wdata_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q <= '0;
      f3_q <= '0;
      wdata_q <= '0;
      lo_q <= '0;
      rsp_data_q <= '0;
      rsp_err_q <= 1'b0;
      mem_en_q <= 1'b0;
      mem_addr_q <= '0;
      mem_we_q <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && req_valid) begin
        addr_q <= req_addr;
        f3_q <= req_funct3;
        wdata_q <= req_wdata;
      end
      lo_q <= lo_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q <= rsp_err_d;
      mem_en_q <= mem_en_d;
      mem_addr_q <= mem_addr_d;
      mem_we_q <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end
  assign req_ready = state_q == S_IDLE;
  assign rsp_valid = state_q == S_RSP;
  assign rsp_data = rsp_data_q;
  assign rsp_err = rsp_err_q;
  assign mem_en = mem_en_q;
  assign mem_addr = mem_addr_q;
  assign mem_we = mem_we_q;
  assign mem_wdata = mem_wdata_q;
endmodule
